// File: rtl/button_scan_ctrl.sv
// Time-multiplexed debounce controller: one shared up/down integrator visits one
// button per clock, and press/release edges are queued in a small event FIFO.
module button_scan_ctrl #(
  parameter int N          = 4,
  parameter int CNT_W      = 18,
  parameter int CNT_MAX    = 25000,
  parameter int HI_TH      = 24000,
  parameter int LO_TH      = 10000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         btn_in,
  input  logic [N-1:0]         mode,
  input  logic                 scan_en,
  output logic [N-1:0]         level,
  output logic [N-1:0]         press,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [$clog2(N)-1:0] ev_id,
  output logic                 ev_edge,
  output logic                 ev_ovf,
  input  logic                 ovf_clr
);

  localparam int PW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = PW + 1;

  localparam logic [CNT_W-1:0] CMAX_V = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HI_V   = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_V   = CNT_W'(LO_TH);
  localparam logic [PW-1:0]    LAST_P = PW'(N - 1);

  // Two-flop synchronizer for the asynchronous button inputs
  logic [N-1:0] sync1, sync2;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Per-button integrator state and the shared scan pointer
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     tog;
  logic [PW-1:0]    ptr;

  logic [CNT_W-1:0] cur_cnt, nxt_cnt;
  logic             cur_s, cur_lvl, nxt_lvl, nxt_tog;
  logic             vis_event, vis_rise, ev_push;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_cnt   = cnt[ptr];
    cur_s     = sync2[ptr];
    cur_lvl   = level[ptr];
    nxt_cnt   = cur_cnt;
    nxt_lvl   = cur_lvl;
    vis_event = 1'b0;
    vis_rise  = 1'b0;
    if (cur_s) begin
      if (cur_cnt < CMAX_V) nxt_cnt = cur_cnt + CNT_W'(1);
      if ((nxt_cnt > HI_V) && !cur_lvl) begin
        nxt_lvl   = 1'b1;
        vis_event = 1'b1;
        vis_rise  = 1'b1;
      end
    end else begin
      if (cur_cnt != '0) nxt_cnt = cur_cnt - CNT_W'(1);
      if ((nxt_cnt < LO_V) && cur_lvl) begin
        nxt_lvl   = 1'b0;
        vis_event = 1'b1;
      end
    end
    // Toggle mode flips only on a press edge; momentary mode follows the level
    if (mode[ptr]) nxt_tog = tog[ptr] ^ (vis_event & vis_rise);
    else           nxt_tog = nxt_lvl;
    ev_push = vis_event & scan_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      level <= '0;
      tog   <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (scan_en) begin
      cnt[ptr]   <= nxt_cnt;
      level[ptr] <= nxt_lvl;
      tog[ptr]   <= nxt_tog;
      ptr        <= (ptr == LAST_P) ? '0 : ptr + PW'(1);
    end
  end

  assign press = tog;

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full, pop, push_ok, drop;

  assign ev_valid  = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = ev_valid & ev_ready;
  assign push_ok   = ev_push & (~fifo_full | pop);
  assign drop      = ev_push & fifo_full & ~pop;

  assign {ev_id, ev_edge} = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)         ev_ovf <= 1'b1;
      else if (ovf_clr) ev_ovf <= 1'b0;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after the pointers
  // mark it written, so clearing it would be wasted logic.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= {ptr, vis_rise};
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Randomized self-checking bench for button_scan_ctrl against a behavioural
// per-button integrator model with a queue-based event FIFO.
module tb_button_scan_ctrl;

  localparam int N       = 4;
  localparam int CMAX    = 8;
  localparam int HI      = 6;
  localparam int LO      = 2;
  localparam int DEPTH   = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in, mode, level, press;
  logic         scan_en, ev_valid, ev_ready, ev_edge, ev_ovf, ovf_clr;
  logic [1:0]   ev_id;

  button_scan_ctrl #(
    .N(N), .CNT_W(18), .CNT_MAX(CMAX), .HI_TH(HI), .LO_TH(LO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .mode(mode), .scan_en(scan_en),
    .level(level), .press(press), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_id(ev_id), .ev_edge(ev_edge), .ev_ovf(ev_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Behavioural model
  typedef struct { int id; bit rise; } ev_t;
  int  m_cnt [N];
  bit  m_lvl [N];
  bit  m_tog [N];
  bit  m_s1  [N];
  bit  m_s2  [N];
  int  m_ptr;
  bit  m_ovf;
  ev_t m_q [$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_lvl[i] = 0; m_tog[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
    end
    m_ptr = 0;
    m_ovf = 0;
    m_q.delete();
  endtask

  function automatic int next_count(int c, bit s);
    if (s) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : 0;
  endfunction

  // Does the coming clock edge produce an event, given the current inputs?
  function automatic bit predict_event();
    int c;
    if (!scan_en) return 0;
    c = next_count(m_cnt[m_ptr], m_s2[m_ptr]);
    if (m_s2[m_ptr]) return (c > HI) && !m_lvl[m_ptr];
    return (c < LO) && m_lvl[m_ptr];
  endfunction

  task automatic model_edge();
    bit pop, ev, rise;
    int k, c;
    pop  = (m_q.size() > 0) && ev_ready;
    ev   = 0;
    rise = 0;
    if (scan_en) begin
      k = m_ptr;
      c = next_count(m_cnt[k], m_s2[k]);
      if (m_s2[k] && c > HI && !m_lvl[k]) begin
        ev = 1; rise = 1; m_lvl[k] = 1;
      end else if (!m_s2[k] && c < LO && m_lvl[k]) begin
        ev = 1; rise = 0; m_lvl[k] = 0;
      end
      m_cnt[k] = c;
      if (mode[k]) begin
        if (ev && rise) m_tog[k] = !m_tog[k];
      end else begin
        m_tog[k] = m_lvl[k];
      end
      m_ptr = (m_ptr + 1) % N;
    end
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back('{id: k, rise: rise});
      else                    m_ovf = 1;
    end
    if (!(ev && m_q.size() == DEPTH && !pop && m_ovf) && ovf_clr) begin
      // a drop this cycle wins over the clear
      if (!(ev && !pop && m_q.size() == DEPTH && m_q[DEPTH-1].id != k)) m_ovf = m_ovf;
    end
    for (int i = 0; i < N; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = btn_in[i];
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_lvl, exp_prs;
    for (int i = 0; i < N; i++) begin
      exp_lvl[i] = m_lvl[i];
      exp_prs[i] = m_tog[i];
    end
    check("level", 32'(level), 32'(exp_lvl));
    check("press", 32'(press), 32'(exp_prs));
    check("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    check("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
    if (m_q.size() > 0) begin
      check("ev_id", 32'(ev_id), 32'(m_q[0].id));
      check("ev_edge", 32'(ev_edge), 32'(m_q[0].rise));
    end
  endtask

  // One clock: model follows the edge using the inputs the DUT sampled
  task automatic cycle();
    bit drop, clr;
    @(posedge clk);
    drop = predict_event() && (m_q.size() == DEPTH) && !ev_ready;
    clr  = ovf_clr;
    model_edge();
    if (!drop && clr) m_ovf = 0;
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_in   = '0;
    mode     = '0;
    scan_en  = 1'b1;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    model_reset();
    #23;
    compare_all();
    rst_n = 1'b1;

    // Press from reset on button 1, then saturation
    btn_in[1] = 1'b1;
    run(60);

    // Bounce rejection on button 2, then a clean release
    btn_in[2] = 1'b1;
    run(40);
    for (int i = 0; i < 50; i++) begin
      btn_in[2] = ~btn_in[2];
      run(4);
    end
    btn_in[2] = 1'b0;
    run(40);

    // Toggle mode: three press/release cycles on button 0
    mode[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_in[0] = 1'b1; run(40);
      btn_in[0] = 1'b0; run(40);
    end

    // Overflow: presses queue, releases are dropped, then clear
    mode = '0; btn_in = '0; ev_ready = 1'b1;
    run(60);
    ev_ready = 1'b0;
    btn_in = '1; run(40);
    btn_in = '0; run(40);
    ovf_clr = 1'b1; run(1);
    ovf_clr = 1'b0; run(2);

    // Pop and push in the same cycle while full: ready only on push cycles
    for (int i = 0; i < 400; i++) begin
      if ((i % 40) == 0) btn_in = ~btn_in;
      ev_ready = (m_q.size() == DEPTH) && predict_event();
      cycle();
    end
    ev_ready = 1'b1;
    run(20);

    // Freeze mid-debounce
    btn_in = 4'b0101;
    run(10);
    scan_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_in = 4'($urandom);
      cycle();
    end
    scan_en = 1'b1;
    btn_in = 4'b0101;
    run(40);

    // Random segments
    for (int seg = 0; seg < 150; seg++) begin
      int hold, bias;
      logic [N-1:0] pat;
      mode = 4'($urandom);
      pat  = 4'($urandom);
      hold = $urandom_range(4, 80);
      bias = $urandom_range(0, 4);
      for (int j = 0; j < hold; j++) begin
        btn_in   = pat ^ (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
        ev_ready = ($urandom_range(0, 3) < bias);
        ovf_clr  = ($urandom_range(0, 31) == 0);
        scan_en  = ($urandom_range(0, 15) != 0);
        cycle();
      end
    end
    ovf_clr = 1'b0; scan_en = 1'b1;

    // Asynchronous reset mid-operation
    ev_ready = 1'b0;
    btn_in = '1;
    run(40);
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_level", 32'(level), 32'(0));
    check("rst_press", 32'(press), 32'(0));
    check("rst_ev_valid", 32'(ev_valid), 32'(0));
    check("rst_ev_ovf", 32'(ev_ovf), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    run(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_scan_ctrl.md
Name: button_scan_ctrl

Overview:
- Time-multiplexed debounce controller for N push-buttons.
- One shared up/down integrator engine serves all buttons round-robin, one button per clock.
- Per-button counters live in a register array; each button has a mode bit selecting momentary or toggle output.
- Debounced press/release edges are queued in a small event FIFO with a valid/ready handshake, read by the UI/correlator control FSM.

Parameters:
- N, 4, number of buttons (2..16)
- CNT_W, 18, integrator counter width
- CNT_MAX, 25000, integrator saturation value
- HI_TH, 24000, debounced level goes 1 when counter > HI_TH
- LO_TH, 10000, debounced level goes 0 when counter < LO_TH
- FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- btn_in  in  N  raw button inputs, asynchronous
- mode  in  N  per-button mode: 1 = toggle, 0 = momentary
- scan_en  in  1  1 = scan pointer advances and engine updates; 0 = freeze all counters and states
- level  out  N  debounced level per button
- press  out  N  per-button output: toggle state (mode=1) or level (mode=0)
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready
- ev_id  out  clog2(N)  button index of the head event
- ev_edge  out  1  1 = press (rising level), 0 = release
- ev_ovf  out  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  in  1  clears ev_ovf

Behaviour:
- Reset (async, rst_n=0) clears:
  - all counters, level, press, toggle bits
  - sync flops, scan pointer (0), FIFO pointers, ev_ovf
  - ev_valid=0
- Synchronizer: btn_in passes through a 2-flop synchronizer. Only the synchronized value s[i] is used.
- Scan: pointer p cycles 0,1,...,N-1,0 at one step per clock while scan_en=1. Each button is visited once every N clocks.
- Visit of button p, with c = cnt[p]:
  - s[p]=1: c' = c+1 if c < CNT_MAX, else c. If c' > HI_TH and level[p]=0: level[p]<=1, generate press event.
  - s[p]=0: c' = c-1 if c > 0, else 0. If c' < LO_TH and level[p]=1: level[p]<=0, generate release event.
  - cnt[p] <= c'. Widths are unsigned CNT_W; no wrap.
- Toggle / press update on a visit:
  - Press event with mode[p]=1: tog[p] <= ~tog[p].
  - mode[p]=0: tog[p] <= new level[p].
  - press = tog for every button. Mode changes take effect on that button's next visit.
- Event push: occurs in the same clock as the visit; the entry is {p, edge}. ev_valid rises the following clock if the FIFO was empty.
- FIFO full on push: the event is dropped and ev_ovf <= 1. level and press still update.
- Simultaneous pop and push when full: the pop frees a slot and the push is accepted; no overflow.
- Pop: occurs on ev_valid && ev_ready. ev_ready while empty is ignored. ev_id and ev_edge hold stable while ev_valid=1 and ev_ready=0.
- ev_ovf: set has priority over ovf_clr in the same cycle.
- At most one event per clock, so FIFO occupancy changes by at most ±1 per cycle.
- scan_en=0: pointer, counters, level and press are frozen. The FIFO still drains.
- rst_n asserted mid-operation: everything clears immediately; pending events are lost.

Test Plan (N=4, CNT_MAX=8, HI_TH=6, LO_TH=2, FIFO_DEPTH=4 unless noted):
1. Press from reset:
   - Stimulus: reset, then btn_in[1]=1 held, mode=0, ev_ready=1.
   - Response: on the 7th visit of button 1 (cnt=7), level[1]=1, press[1]=1 and one event {id=1, edge=1} is popped. cnt saturates at 8; no further events.
2. Bounce rejection:
   - Stimulus: button 2 reaches level=1 (cnt=8), then btn_in[2] toggles every 4 clocks for 200 clocks.
   - Response: cnt stays ≥2, level[2] stays 1, no event.
   - Stimulus: then hold btn_in[2]=0.
   - Response: release event after cnt drops to 1 (7 visits).
3. Toggle mode:
   - Stimulus: mode[0]=1; three full press/release cycles on button 0.
   - Response: press[0] goes 1, 0, 1 on successive press events; 6 events alternate edge 1/0.
4. FIFO overflow:
   - Stimulus: ev_ready=0; all 4 buttons press simultaneously, then release.
   - Response: 4 press events queued in index order 0..3; the 4 release events are dropped; ev_ovf=1, while level=0000.
   - Stimulus: ovf_clr.
   - Response: ev_ovf=0.
5. Full-FIFO pop+push:
   - Stimulus: FIFO full; assert ev_ready in the same cycle as a new event push.
   - Response: occupancy stays 4, ev_ovf stays 0, new event at the tail.
6. Freeze and reset:
   - Stimulus: scan_en=0 mid-debounce.
   - Response: cnt values unchanged for 100 clocks.
   - Stimulus: assert rst_n=0 asynchronously.
   - Response: level, press, ev_valid and ev_ovf are 0 immediately, without a clock edge.
